// File: rtl/arith_share_sched.sv
// arith_share_sched
//   Shares one pipelined arithmetic unit among NUM_REQ requesters.
//   Ops are granted round-robin, tagged with the requester index in the
//   ctl tag field and registered toward the unit. Results return through a
//   single register and are steered to the requester named by their tag.
//   A per-requester credit counter caps outstanding ops at MAX_OUT so that
//   no single requester can fill the unit pipeline.
//
//   Tag field: ctl[CTL_BITS-1:TAG_LSB]. On issue the whole field is replaced
//   by the zero-extended requester index. On return the whole field is
//   checked, so a tag >= NUM_REQ is consumed and dropped. The field is then
//   cleared before the result is presented to the requester.
//
// Ports
//   i_clk, i_rst_n               clock, async active-low reset
//   i_req_val/dat/ctl, o_req_rdy requester op channel (NUM_REQ lanes)
//   o_unit_val/dat/ctl, i_unit_rdy  op channel to the unit
//   i_unit_val/dat/ctl, o_unit_rdy  result channel from the unit
//   o_rsp_val/dat/ctl, i_rsp_rdy    result channel to requesters
//   o_busy                       credits outstanding or a register valid
module arith_share_sched #(
   parameter int NUM_REQ  = 4,
   parameter int DAT_BITS = 762,
   parameter int RES_BITS = 381,
   parameter int CTL_BITS = 12,
   parameter int TAG_LSB  = 8,
   parameter int MAX_OUT  = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [NUM_REQ-1:0]           i_req_val,
   input  logic [NUM_REQ*DAT_BITS-1:0]  i_req_dat,
   input  logic [NUM_REQ*CTL_BITS-1:0]  i_req_ctl,
   output logic [NUM_REQ-1:0]           o_req_rdy,
   output logic                         o_unit_val,
   output logic [DAT_BITS-1:0]          o_unit_dat,
   output logic [CTL_BITS-1:0]          o_unit_ctl,
   input  logic                         i_unit_rdy,
   input  logic                         i_unit_val,
   input  logic [RES_BITS-1:0]          i_unit_dat,
   input  logic [CTL_BITS-1:0]          i_unit_ctl,
   output logic                         o_unit_rdy,
   output logic [NUM_REQ-1:0]           o_rsp_val,
   output logic [RES_BITS-1:0]          o_rsp_dat,
   output logic [CTL_BITS-1:0]          o_rsp_ctl,
   input  logic [NUM_REQ-1:0]           i_rsp_rdy,
   output logic                         o_busy
);

   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TAGW = CTL_BITS - TAG_LSB;
   localparam int CNTW = $clog2(MAX_OUT + 1);
   localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(MAX_OUT);
   localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
   localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};

   // Round-robin successor of a requester index, wrapping at NUM_REQ.
   function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx);
      if (int'(idx) >= NUM_REQ - 1) begin
         return {IDXW{1'b0}};
      end else begin
         return idx + IDXW'(1);
      end
   endfunction

   // Issue-side state
   logic                 unit_val_r;
   logic [DAT_BITS-1:0]  unit_dat_r;
   logic [CTL_BITS-1:0]  unit_ctl_r;
   logic [IDXW-1:0]      ptr_r;
   logic [CNTW-1:0]      cnt_r   [NUM_REQ];
   logic [CNTW-1:0]      cnt_nxt_s [NUM_REQ];

   // Return-side state
   logic [NUM_REQ-1:0]   rsp_val_r;
   logic [RES_BITS-1:0]  rsp_dat_r;
   logic [CTL_BITS-1:0]  rsp_ctl_r;
   logic [IDXW-1:0]      held_idx_r;

   logic                 load_en_s;
   logic [NUM_REQ-1:0]   eligible_s;
   logic                 grant_vld_s;
   logic [IDXW-1:0]      grant_idx_s;
   logic [IDXW-1:0]      cand_s;
   logic [DAT_BITS-1:0]  sel_dat_s;
   logic [CTL_BITS-1:0]  sel_ctl_s;
   logic [NUM_REQ-1:0]   req_rdy_s;

   logic [TAGW-1:0]      ret_tag_s;
   logic                 ret_ok_s;
   logic [NUM_REQ-1:0]   ret_onehot_s;
   logic [CTL_BITS-1:0]  ret_ctl_s;
   logic                 rsp_any_s;
   logic                 rsp_accept_s;
   logic                 unit_rdy_s;
   logic                 ret_fire_s;
   logic                 busy_s;

   // The issue register may load whenever it is empty or being drained.
   assign load_en_s = !unit_val_r | i_unit_rdy;

   // A requester competes only while it has credit left.
   always_comb begin
      eligible_s = {NUM_REQ{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         eligible_s[k] = i_req_val[k] && (cnt_r[k] < CNT_MAX);
      end
   end

   // Round-robin search: first eligible requester at or after ptr_r.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_idx_s = {IDXW{1'b0}};
      cand_s      = ptr_r;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_vld_s && eligible_s[cand_s]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = cand_s;
         end else begin
            grant_vld_s = grant_vld_s;
         end
         cand_s = next_idx(cand_s);
      end
   end

   // Operand/ctl mux for the granted requester, with the tag field rewritten.
   always_comb begin
      sel_dat_s = {DAT_BITS{1'b0}};
      sel_ctl_s = {CTL_BITS{1'b0}};
      req_rdy_s = {NUM_REQ{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_idx_s == IDXW'(k)) begin
            sel_dat_s    = i_req_dat[k*DAT_BITS +: DAT_BITS];
            sel_ctl_s    = i_req_ctl[k*CTL_BITS +: CTL_BITS];
            req_rdy_s[k] = load_en_s & grant_vld_s;
         end else begin
            req_rdy_s[k] = 1'b0;
         end
      end
      sel_ctl_s[TAG_LSB +: TAGW] = TAGW'(grant_idx_s);
   end

   // Issue register and round-robin pointer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         unit_val_r <= 1'b0;
         unit_dat_r <= {DAT_BITS{1'b0}};
         unit_ctl_r <= {CTL_BITS{1'b0}};
         ptr_r      <= {IDXW{1'b0}};
      end else if (load_en_s) begin
         if (grant_vld_s) begin
            unit_val_r <= 1'b1;
            unit_dat_r <= sel_dat_s;
            unit_ctl_r <= sel_ctl_s;
            ptr_r      <= next_idx(grant_idx_s);
         end else begin
            unit_val_r <= 1'b0;
         end
      end
   end

   // Return-side decode: tag range check, one-hot steering, tag clearing.
   always_comb begin
      ret_tag_s = i_unit_ctl[TAG_LSB +: TAGW];
      ret_ok_s  = (int'(ret_tag_s) < NUM_REQ);
      ret_ctl_s = i_unit_ctl;
      ret_ctl_s[TAG_LSB +: TAGW] = {TAGW{1'b0}};
      ret_onehot_s = {NUM_REQ{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         ret_onehot_s[k] = ret_ok_s && (ret_tag_s == TAGW'(k));
      end
      rsp_any_s    = |rsp_val_r;
      rsp_accept_s = rsp_any_s & i_rsp_rdy[held_idx_r];
      unit_rdy_s   = !rsp_any_s | rsp_accept_s;
      ret_fire_s   = i_unit_val & unit_rdy_s;
   end

   // Return register; a dropped (out-of-range) result leaves it empty.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rsp_val_r  <= {NUM_REQ{1'b0}};
         rsp_dat_r  <= {RES_BITS{1'b0}};
         rsp_ctl_r  <= {CTL_BITS{1'b0}};
         held_idx_r <= {IDXW{1'b0}};
      end else if (ret_fire_s) begin
         rsp_val_r <= ret_onehot_s;
         if (ret_ok_s) begin
            rsp_dat_r  <= i_unit_dat;
            rsp_ctl_r  <= ret_ctl_s;
            held_idx_r <= IDXW'(ret_tag_s);
         end
      end else if (rsp_accept_s) begin
         rsp_val_r <= {NUM_REQ{1'b0}};
      end
   end

   // Credit update: +1 on op accept, -1 on result accept, saturating at both ends.
   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         cnt_nxt_s[k] = cnt_r[k];
         case ({req_rdy_s[k] & i_req_val[k] & (cnt_r[k] != CNT_MAX),
                rsp_val_r[k] & i_rsp_rdy[k] & (cnt_r[k] != CNT_ZERO)})
            2'b10:   cnt_nxt_s[k] = cnt_r[k] + CNT_ONE;
            2'b01:   cnt_nxt_s[k] = cnt_r[k] - CNT_ONE;
            default: cnt_nxt_s[k] = cnt_r[k];
         endcase
      end
   end

   // Credit counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cnt_r[k] <= CNT_ZERO;
         end
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cnt_r[k] <= cnt_nxt_s[k];
         end
      end
   end

   // Busy while any credit is held or either register is occupied.
   always_comb begin
      busy_s = unit_val_r | rsp_any_s;
      for (int k = 0; k < NUM_REQ; k++) begin
         busy_s = busy_s | (cnt_r[k] != CNT_ZERO);
      end
   end

   assign o_req_rdy  = req_rdy_s;
   assign o_unit_val = unit_val_r;
   assign o_unit_dat = unit_dat_r;
   assign o_unit_ctl = unit_ctl_r;
   assign o_unit_rdy = unit_rdy_s;
   assign o_rsp_val  = rsp_val_r;
   assign o_rsp_dat  = rsp_dat_r;
   assign o_rsp_ctl  = rsp_ctl_r;
   assign o_busy     = busy_s;

endmodule

// File: tb/tb_arith_share_sched.sv
// tb_arith_share_sched
//   Directed bench for arith_share_sched with default parameters
//   (4 requesters, MAX_OUT 8, tag at ctl[11:8]). Inputs change 2 time units
//   after the rising edge; outputs are sampled there or 1 unit later.
module tb_arith_share_sched;

   localparam int N  = 4;
   localparam int DB = 762;
   localparam int RB = 381;
   localparam int CB = 12;

   logic                i_clk = 1'b0;
   logic                i_rst_n;
   logic [N-1:0]        i_req_val;
   logic [N*DB-1:0]     i_req_dat;
   logic [N*CB-1:0]     i_req_ctl;
   logic [N-1:0]        o_req_rdy;
   logic                o_unit_val;
   logic [DB-1:0]       o_unit_dat;
   logic [CB-1:0]       o_unit_ctl;
   logic                i_unit_rdy;
   logic                i_unit_val;
   logic [RB-1:0]       i_unit_dat;
   logic [CB-1:0]       i_unit_ctl;
   logic                o_unit_rdy;
   logic [N-1:0]        o_rsp_val;
   logic [RB-1:0]       o_rsp_dat;
   logic [CB-1:0]       o_rsp_ctl;
   logic [N-1:0]        i_rsp_rdy;
   logic                o_busy;

   int vec_cnt = 0;
   int err_cnt = 0;
   int seen;

   arith_share_sched dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_val(i_req_val), .i_req_dat(i_req_dat), .i_req_ctl(i_req_ctl),
      .o_req_rdy(o_req_rdy),
      .o_unit_val(o_unit_val), .o_unit_dat(o_unit_dat), .o_unit_ctl(o_unit_ctl),
      .i_unit_rdy(i_unit_rdy),
      .i_unit_val(i_unit_val), .i_unit_dat(i_unit_dat), .i_unit_ctl(i_unit_ctl),
      .o_unit_rdy(o_unit_rdy),
      .o_rsp_val(o_rsp_val), .o_rsp_dat(o_rsp_dat), .o_rsp_ctl(o_rsp_ctl),
      .i_rsp_rdy(i_rsp_rdy), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [767:0] got, input logic [767:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DB-1:0] dat_of(input int k);
      logic [DB-1:0] d;
      d = '0;
      d[DB-1 -: 8] = 8'(k + 1);
      d[63:0]      = 64'hDEAD_BEEF_0000_0000 + 64'(k);
      return d;
   endfunction

   // Requester ctl carries junk in the tag field; it must be overwritten.
   function automatic logic [CB-1:0] ctl_in(input int k);
      return 12'hB50 + 12'(k);
   endfunction

   function automatic logic [CB-1:0] ctl_exp(input int k);
      return 12'h050 + 12'(k) + (12'(k) << 8);
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask

   task automatic drive_idle();
      i_req_val  = '0;
      for (int k = 0; k < N; k++) begin
         i_req_dat[k*DB +: DB] = dat_of(k);
         i_req_ctl[k*CB +: CB] = ctl_in(k);
      end
      i_unit_rdy = 1'b1;
      i_unit_val = 1'b0;
      i_unit_dat = '0;
      i_unit_ctl = '0;
      i_rsp_rdy  = '0;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      drive_idle();
      repeat (3) tick();
      check_eq("rst_unit_val", o_unit_val, 1'b0);
      check_eq("rst_rsp_val", o_rsp_val, 4'b0000);
      check_eq("rst_busy", o_busy, 1'b0);
      i_rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      i_rst_n = 1'b0;
      drive_idle();

      // 1. reset state and asynchronous clear mid-cycle
      do_reset();
      i_req_val = 4'b0001;
      tick();
      check_eq("t1_issue_val", o_unit_val, 1'b1);
      check_eq("t1_busy", o_busy, 1'b1);
      #1 i_rst_n = 1'b0;
      #1;
      check_eq("t1_async_val", o_unit_val, 1'b0);
      check_eq("t1_async_busy", o_busy, 1'b0);
      do_reset();

      // 2. all requesters valid: grant order 0,1,2,3,0,...
      i_req_val = 4'b1111;
      for (int n = 0; n < 8; n++) begin
         #1;
         check_eq("t2_rdy", o_req_rdy, 4'b0001 << (n % 4));
         tick();
         check_eq("t2_val", o_unit_val, 1'b1);
         check_eq("t2_ctl", o_unit_ctl, ctl_exp(n % 4));
         check_eq("t2_dat", o_unit_dat, dat_of(n % 4));
      end

      // 3. requester 2 alone: credit limit of 8, then one return frees a slot
      do_reset();
      i_req_val = 4'b0100;
      seen = 0;
      for (int n = 0; n < 10; n++) begin
         #1;
         if (o_req_rdy[2]) seen++;
         tick();
      end
      check_eq("t3_issued", 32'(seen), 32'd8);
      check_eq("t3_rdy_blocked", o_req_rdy, 4'b0000);
      i_unit_val = 1'b1;
      i_unit_ctl = 12'h2AB;
      i_unit_dat = RB'(48'h1234_5678_9ABC);
      #1;
      check_eq("t3_unit_rdy", o_unit_rdy, 1'b1);
      tick();
      i_unit_val = 1'b0;
      i_rsp_rdy  = 4'b0100;
      #1;
      check_eq("t3_rsp_val", o_rsp_val, 4'b0100);
      check_eq("t3_rsp_ctl", o_rsp_ctl, 12'h0AB);
      check_eq("t3_rsp_dat", o_rsp_dat, RB'(48'h1234_5678_9ABC));
      check_eq("t3_rdy_still_blocked", o_req_rdy, 4'b0000);
      tick();
      check_eq("t3_rsp_gone", o_rsp_val, 4'b0000);
      check_eq("t3_rdy_freed", o_req_rdy, 4'b0100);
      i_rsp_rdy = 4'b0000;
      tick();
      check_eq("t3_ninth_val", o_unit_val, 1'b1);
      check_eq("t3_ninth_ctl", o_unit_ctl, ctl_exp(2));
      check_eq("t3_rdy_reblocked", o_req_rdy, 4'b0000);

      // 4. unit backpressure holds the op and the pointer
      do_reset();
      i_req_val  = 4'b1111;
      i_unit_rdy = 1'b0;
      #1;
      check_eq("t4_first_rdy", o_req_rdy, 4'b0001);
      tick();
      for (int n = 0; n < 5; n++) begin
         check_eq("t4_hold_rdy", o_req_rdy, 4'b0000);
         check_eq("t4_hold_val", o_unit_val, 1'b1);
         check_eq("t4_hold_ctl", o_unit_ctl, ctl_exp(0));
         check_eq("t4_hold_dat", o_unit_dat, dat_of(0));
         tick();
      end
      i_unit_rdy = 1'b1;
      #1;
      check_eq("t4_resume_rdy", o_req_rdy, 4'b0010);
      tick();
      check_eq("t4_resume_ctl", o_unit_ctl, ctl_exp(1));

      // 5. return stall: tag 3 held, tag 1 waits behind it
      do_reset();
      i_unit_val = 1'b1;
      i_unit_ctl = 12'h3C1;
      i_unit_dat = RB'(32'hAAAA_0001);
      #1;
      check_eq("t5_first_unit_rdy", o_unit_rdy, 1'b1);
      tick();
      i_unit_ctl = 12'h1C2;
      i_unit_dat = RB'(32'hBBBB_0002);
      for (int n = 0; n < 4; n++) begin
         #1;
         check_eq("t5_stall_unit_rdy", o_unit_rdy, 1'b0);
         check_eq("t5_stall_rsp_val", o_rsp_val, 4'b1000);
         check_eq("t5_stall_rsp_ctl", o_rsp_ctl, 12'h0C1);
         check_eq("t5_stall_rsp_dat", o_rsp_dat, RB'(32'hAAAA_0001));
         tick();
      end
      i_rsp_rdy = 4'b1000;
      #1;
      check_eq("t5_release_unit_rdy", o_unit_rdy, 1'b1);
      tick();
      i_unit_val = 1'b0;
      i_rsp_rdy  = 4'b0000;
      #1;
      check_eq("t5_second_val", o_rsp_val, 4'b0010);
      check_eq("t5_second_ctl", o_rsp_ctl, 12'h0C2);
      check_eq("t5_second_dat", o_rsp_dat, RB'(32'hBBBB_0002));
      i_rsp_rdy = 4'b0010;
      tick();
      check_eq("t5_drained_val", o_rsp_val, 4'b0000);
      check_eq("t5_no_credit_wrap", o_busy, 1'b0);

      // 6. simultaneous accept/return at cnt 5, then out-of-range tags
      do_reset();
      i_req_val = 4'b0001;
      repeat (5) tick();
      i_req_val  = 4'b0000;
      i_unit_val = 1'b1;
      i_unit_ctl = 12'h033;
      i_unit_dat = RB'(16'h5A5A);
      tick();
      i_unit_val = 1'b0;
      i_req_val  = 4'b0001;
      i_rsp_rdy  = 4'b0001;
      #1;
      check_eq("t6_both_rsp_val", o_rsp_val, 4'b0001);
      check_eq("t6_both_req_rdy", o_req_rdy, 4'b0001);
      tick();
      i_rsp_rdy = 4'b0000;
      seen = 0;
      for (int n = 0; n < 5; n++) begin
         #1;
         if (o_req_rdy[0]) seen++;
         tick();
      end
      check_eq("t6_remaining_credit", 32'(seen), 32'd3);
      i_req_val  = 4'b0000;
      i_unit_val = 1'b1;
      i_unit_ctl = 12'h755;
      #1;
      check_eq("t6_tag7_unit_rdy", o_unit_rdy, 1'b1);
      tick();
      i_unit_ctl = 12'h412;
      #1;
      check_eq("t6_tag7_dropped", o_rsp_val, 4'b0000);
      tick();
      i_unit_val = 1'b0;
      i_req_val  = 4'b0001;
      #1;
      check_eq("t6_tag4_dropped", o_rsp_val, 4'b0000);
      check_eq("t6_credit_unchanged", o_req_rdy, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
